cpu_sequencer: RTL and testbench

- Multi-cycle control FSM for the 4-bit CPU core.
- Fetches 8-bit instructions over an instruction-memory handshake and decodes them.
- Drives the ALU opcode and register-file indices and write enable.
- Sequences data-memory load/store handshakes, keeps the Z/N flag register and the program counter, and resolves conditional jumps.

---
 rtl/cpu_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/exec/mem control FSM for the 4-bit CPU core.
// Optional single-step mode: define CPU_SEQUENCER_SINGLE_STEP_EN to add the step input.
module cpu_sequencer #(
    parameter int              PC_W        = 4,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              ACK_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    input  logic            step,
`endif
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_data,
    output logic [3:0]      alu_op,
    input  logic            alu_z,
    input  logic            alu_n,
    input  logic [3:0]      alu_out,
    output logic [1:0]      rf_sel_x,
    output logic [1:0]      rf_sel_y,
    output logic            rf_we,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic [PC_W-1:0] pc,
    output logic            flag_z,
    output logic            flag_n,
    output logic            busy,
    output logic            fault
);

    localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_FAULT
    } state_t;

    state_t           state, state_next;
    logic [7:0]       ir;
    logic [CNT_W-1:0] wait_cnt;
    logic [3:0]       op;
    logic             is_arith, is_mem, is_st, is_jump, taken;
    logic             timeout_hit, start_ok;
    state_t           retire_state;
    logic [PC_W-1:0]  target, pc_inc;

    assign op       = ir[7:4];
    assign is_arith = (op != 4'd0) && (op <= 4'd8);
    assign is_mem   = (op[3:1] == 3'b111);
    assign is_st    = (op == 4'd15);
    assign is_jump  = (op >= 4'd9) && (op <= 4'd13);
    assign target   = PC_W'(alu_out);
    assign pc_inc   = pc + PC_W'(1);

    always_comb begin
        case (op)
            4'd9:    taken = 1'b1;
            4'd10:   taken = flag_z;
            4'd11:   taken = ~flag_z;
            4'd12:   taken = flag_n;
            4'd13:   taken = ~flag_n;
            default: taken = 1'b0;
        endcase
    end

    assign timeout_hit = (ACK_TIMEOUT > 0) && (wait_cnt == CNT_W'(ACK_TIMEOUT));

`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    logic step_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) step_q <= 1'b0;
        else     step_q <= step;
    end
    assign start_ok     = step & ~step_q;
    assign retire_state = S_IDLE;
`else
    assign start_ok     = 1'b1;
    assign retire_state = run ? S_FETCH : S_IDLE;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (run && start_ok) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack)         state_next = S_EXEC;
                else if (timeout_hit) state_next = S_FAULT;
            end
            S_EXEC: begin
                state_next = is_mem ? S_MEM : retire_state;
            end
            S_MEM: begin
                if (dmem_ack)         state_next = retire_state;
                else if (timeout_hit) state_next = S_FAULT;
            end
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req = 1'b0;
        alu_op   = 4'd0;
        rf_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        busy     = 1'b1;
        case (state)
            S_FETCH: imem_req = 1'b1;
            S_EXEC: begin
                alu_op = op;
                rf_we  = is_arith;
            end
            S_MEM: begin
                alu_op   = op;
                dmem_req = 1'b1;
                dmem_we  = is_st;
                rf_we    = ~is_st & dmem_ack;
            end
            default: busy = 1'b0;
        endcase
    end

    assign imem_addr = pc;
    assign rf_sel_x  = ir[3:2];
    assign rf_sel_y  = ir[1:0];

    // Datapath registers: instruction, PC, flags, fault and handshake wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir       <= '0;
            pc       <= RESET_PC;
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
            fault    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (state_next != state)
                wait_cnt <= '0;
            else if (state == S_FETCH || state == S_MEM)
                wait_cnt <= wait_cnt + CNT_W'(1);

            if (state_next == S_FAULT)
                fault <= 1'b1;

            if (state == S_FETCH && imem_ack)
                ir <= imem_data;

            if (state == S_EXEC) begin
                if (is_arith) begin
                    flag_z <= alu_z;
                    flag_n <= alu_n;
                end
                if (is_jump)
                    pc <= taken ? target : pc_inc;
                else if (!is_mem)
                    pc <= pc_inc;
            end

            if (state == S_MEM && dmem_ack) begin
                pc <= pc_inc;
                if (!is_st) begin
                    flag_z <= alu_z;
                    flag_n <= alu_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed and random instructions against an ISA-level model.
module tb_cpu_sequencer;

    localparam int PC_W = 4;

    logic            clk = 1'b0;
    logic            rst, run, imem_ack, alu_z, alu_n, dmem_ack;
    logic [7:0]      imem_data;
    logic [3:0]      alu_out;
    logic            imem_req, rf_we, dmem_req, dmem_we, flag_z, flag_n, busy, fault;
    logic [PC_W-1:0] imem_addr, pc;
    logic [3:0]      alu_op;
    logic [1:0]      rf_sel_x, rf_sel_y;
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    logic            step = 1'b0;
`endif

    cpu_sequencer #(.PC_W(PC_W), .RESET_PC('0), .ACK_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
        .step(step),
`endif
        .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .alu_op(alu_op), .alu_z(alu_z), .alu_n(alu_n), .alu_out(alu_out),
        .rf_sel_x(rf_sel_x), .rf_sel_y(rf_sel_y), .rf_we(rf_we),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .pc(pc), .flag_z(flag_z), .flag_n(flag_n), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    // Architectural model state
    logic [PC_W-1:0] m_pc;
    logic            m_z, m_n;

    task automatic model_reset();
        m_pc = '0;
        m_z  = 1'b0;
        m_n  = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        imem_data = '0; alu_out = '0; alu_z = 1'b0; alu_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // From IDLE (just after a negedge): raise run, land on the first FETCH cycle's negedge
    task automatic start_run();
        run = 1'b1;
        #1;
        ntests++;
        if ({imem_req, busy} !== 2'b00) begin
            nfail++;
            $display("FAIL start_idle: req/busy=%b expected 00", {imem_req, busy});
        end
        @(negedge clk);
    endtask

    // Executes one instruction from its first FETCH cycle; checks every cycle against the model
    task automatic run_instr(input logic [7:0] instr, input int fdelay, input int mdelay,
                             input logic [3:0] aout, input logic run_after);
        logic [3:0] op;
        logic       z, n, exp_we, tk;
        op = instr[7:4];
        z  = (aout == 4'd0);
        n  = aout[3];
        for (int i = 0; i <= fdelay; i++) begin
            imem_ack  = (i == fdelay);
            imem_data = (i == fdelay) ? instr : 8'($urandom);
            #1;
            ntests++;
            if ({imem_req, imem_addr, busy, dmem_req, alu_op, rf_we} !== {1'b1, m_pc, 1'b1, 1'b0, 4'd0, 1'b0}) begin
                nfail++;
                $display("FAIL fetch(%h) cyc %0d: req=%b addr=%h busy=%b dreq=%b op=%h we=%b expected req=1 addr=%h busy=1 dreq=0 op=0 we=0",
                         instr, i, imem_req, imem_addr, busy, dmem_req, alu_op, rf_we, m_pc);
            end
            @(negedge clk);
        end
        imem_ack  = 1'b0;
        imem_data = 8'($urandom);
        alu_out   = aout;
        alu_z     = z;
        alu_n     = n;
        if (op < 4'd14) run = run_after;
        exp_we = (op >= 4'd1) && (op <= 4'd8);
        #1;
        ntests++;
        if ({alu_op, rf_sel_x, rf_sel_y, rf_we, imem_req, dmem_req, pc} !==
            {op, instr[3:2], instr[1:0], exp_we, 1'b0, 1'b0, m_pc}) begin
            nfail++;
            $display("FAIL exec(%h): op=%h x=%0d y=%0d we=%b ireq=%b dreq=%b pc=%h expected op=%h x=%0d y=%0d we=%b ireq=0 dreq=0 pc=%h",
                     instr, alu_op, rf_sel_x, rf_sel_y, rf_we, imem_req, dmem_req, pc,
                     op, instr[3:2], instr[1:0], exp_we, m_pc);
        end
        @(negedge clk);
        if (op >= 4'd14) begin
            for (int j = 0; j <= mdelay; j++) begin
                dmem_ack = (j == mdelay);
                if (j == ((mdelay > 0) ? 1 : 0)) run = run_after;
                #1;
                ntests++;
                if ({dmem_req, dmem_we, alu_op, rf_we, imem_req, pc} !==
                    {1'b1, (op == 4'd15), op, (op == 4'd14) && (j == mdelay), 1'b0, m_pc}) begin
                    nfail++;
                    $display("FAIL mem(%h) cyc %0d: dreq=%b dwe=%b op=%h we=%b ireq=%b pc=%h expected dreq=1 dwe=%b op=%h we=%b ireq=0 pc=%h",
                             instr, j, dmem_req, dmem_we, alu_op, rf_we, imem_req, pc,
                             (op == 4'd15), op, (op == 4'd14) && (j == mdelay), m_pc);
                end
                @(negedge clk);
            end
            dmem_ack = 1'b0;
        end
        // Architectural effect of the instruction
        case (op)
            4'd10:   tk = m_z;
            4'd11:   tk = ~m_z;
            4'd12:   tk = m_n;
            4'd13:   tk = ~m_n;
            default: tk = 1'b0;
        endcase
        if (op == 4'd9 || tk) m_pc = aout;
        else                  m_pc = m_pc + 1'b1;
        if (exp_we || op == 4'd14) begin
            m_z = z;
            m_n = n;
        end
        #1;
        ntests++;
        if ({pc, flag_z, flag_n, fault, imem_req, busy, rf_we, dmem_req, alu_op} !==
            {m_pc, m_z, m_n, 1'b0, run_after, run_after, 1'b0, 1'b0, 4'd0}) begin
            nfail++;
            $display("FAIL retire(%h): pc=%h z=%b n=%b fault=%b ireq=%b busy=%b we=%b dreq=%b op=%h expected pc=%h z=%b n=%b fault=0 ireq=%b busy=%b we=0 dreq=0 op=0",
                     instr, pc, flag_z, flag_n, fault, imem_req, busy, rf_we, dmem_req, alu_op,
                     m_pc, m_z, m_n, run_after, run_after);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        imem_data = '0; alu_out = '0; alu_z = 1'b0; alu_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        ntests++;
        if ({imem_req, dmem_req, dmem_we, rf_we, busy, fault, alu_op, pc, flag_z, flag_n} !== '0) begin
            nfail++;
            $display("FAIL reset_state: ireq=%b dreq=%b dwe=%b we=%b busy=%b fault=%b op=%h pc=%h z=%b n=%b expected all 0",
                     imem_req, dmem_req, dmem_we, rf_we, busy, fault, alu_op, pc, flag_z, flag_n);
        end
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        ntests++;
        if ({imem_req, busy} !== 2'b00) begin
            nfail++;
            $display("FAIL idle_hold: ireq/busy=%b expected 00", {imem_req, busy});
        end
    endtask

    task automatic test_arith();
        start_run();
        run_instr(8'h1E, 1, 0, 4'h0, 1'b1);
    endtask

    task automatic test_jumps();
        run_instr(8'hA4, 0, 0, 4'h9, 1'b1);
        run_instr(8'h90, 0, 0, 4'h0, 1'b1);
        run_instr(8'h1B, 0, 0, 4'h5, 1'b1);
        run_instr(8'hA4, 2, 0, 4'h9, 1'b1);
    endtask

    task automatic test_load();
        run_instr(8'hE6, 0, 3, 4'h8, 1'b1);
    endtask

    task automatic test_store_wrap();
        run_instr(8'h90, 0, 0, 4'hF, 1'b1);
        run_instr(8'hF6, 1, 2, 4'h3, 1'b1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++)
            run_instr(8'($urandom), $urandom_range(0, 4), $urandom_range(0, 4), 4'($urandom), 1'b1);
    endtask

    task automatic test_stop();
        run_instr(8'hE6, 1, 3, 4'h2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            ntests++;
            if ({imem_req, busy, dmem_req} !== 3'b000) begin
                nfail++;
                $display("FAIL stop_idle cyc %0d: ireq/busy/dreq=%b expected 000", k, {imem_req, busy, dmem_req});
            end
        end
    endtask

    task automatic test_async_reset();
        start_run();
        run_instr(8'h9C, 0, 0, 4'h6, 1'b1);
        imem_ack = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        ntests++;
        if ({imem_req, busy, pc} !== {1'b0, 1'b0, 4'h0}) begin
            nfail++;
            $display("FAIL async_reset: ireq=%b busy=%b pc=%h expected ireq=0 busy=0 pc=0", imem_req, busy, pc);
        end
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_timeout();
        start_run();
        imem_ack = 1'b0;
        for (int k = 0; k <= 15; k++) begin
            #1;
            ntests++;
            if ({imem_req, fault, busy} !== 3'b101) begin
                nfail++;
                $display("FAIL timeout_wait cyc %0d: ireq/fault/busy=%b expected 101", k, {imem_req, fault, busy});
            end
            @(negedge clk);
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            ntests++;
            if ({fault, busy, imem_req, dmem_req} !== 4'b1000) begin
                nfail++;
                $display("FAIL fault_sticky cyc %0d: fault/busy/ireq/dreq=%b expected 1000", k, {fault, busy, imem_req, dmem_req});
            end
            imem_ack = 1'($urandom);
            @(negedge clk);
        end
        apply_reset();
        ntests++;
        if (fault !== 1'b0) begin
            nfail++;
            $display("FAIL fault_clear: fault=%b expected 0", fault);
        end
        start_run();
        run_instr(8'h00, 15, 0, 4'h0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_arith();
        test_jumps();
        test_load();
        test_store_wrap();
        test_random();
        test_stop();
        test_async_reset();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
